// File: rtl/mesh_terminal_rx.sv
// mesh_terminal_rx: mesh terminal receiver. It pops packets from the mesh, checks their address and buffers local packets in a first-word-fall-through FIFO.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   pndng      mesh has a packet pending for this terminal
//   data_out   mesh packet, valid while pndng=1
//   pop        one-cycle pulse that consumes data_out
//   rx_valid   buffer holds at least one packet
//   rx_data    packet at the head of the buffer (0 when empty)
//   rx_ready   host accepts rx_data when rx_valid=1
//   rx_count   accepted packets (wraps)
//   err_count  misrouted packets dropped (saturates)
//   buf_full   buffer holds fifo_depth packets
module mesh_terminal_rx #(
  parameter int pckg_sz = 40,
  parameter int fifo_depth = 4,
  parameter logic [3:0] ROW = 4'd0,
  parameter logic [3:0] COL = 4'd1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_ready,
  output logic [15:0]        rx_count,
  output logic [7:0]         err_count,
  output logic               buf_full
);
  localparam int AW = $clog2(fifo_depth);
  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;
  state_t r_state, w_next;
  logic r_arm;
  logic [pckg_sz-1:0] r_mem [fifo_depth];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_occ;
  logic w_rd, w_hit, w_wr;
  assign w_rd = rx_valid && rx_ready;
  // gating pop with pndng discards the capture when the mesh withdraws mid-POP
  assign pop = (r_state == POP) && pndng;
  assign w_hit = (data_out[pckg_sz-9 -: 4] == ROW) && (data_out[pckg_sz-13 -: 4] == COL);
  assign w_wr = pop && w_hit && (!buf_full || w_rd);
  assign rx_valid = r_occ != '0;
  assign buf_full = r_occ == (AW+1)'(fifo_depth);
  assign rx_data = rx_valid ? r_mem[r_rd_ptr] : '0;
  // r_arm delays the first IDLE->POP by one edge after reset release
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE)
      w_next = (pndng && r_arm && (!buf_full || w_rd)) ? POP : IDLE;
    else if (r_state == POP)
      w_next = GAP;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_arm <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ <= '0;
      rx_count <= '0;
      err_count <= '0;
    end else begin
      r_state <= w_next;
      r_arm <= 1'b1;
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_occ <= r_occ + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      if (w_wr) rx_count <= rx_count + 16'd1;
      if (pop && !w_hit && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= data_out;
endmodule

// File: tb/tb_mesh_terminal_rx.sv
// tb_mesh_terminal_rx: randomized and directed bench for mesh_terminal_rx against a queue-based reference model.
module tb_mesh_terminal_rx;
  localparam int P = 40, D = 4;
  logic clk = 0, reset = 0, pndng = 0, rx_ready = 0;
  logic [P-1:0] data_out = '0;
  logic pop, rx_valid, buf_full;
  logic [P-1:0] rx_data;
  logic [15:0] rx_count;
  logic [7:0] err_count;
  int n_tests = 0, n_fail = 0;
  logic [P-1:0] src[$], mq[$];
  int pc[$];
  int m_rx = 0, m_err = 0, pops = 0, cyc = 0, last_pop = -100, edges = 0, rdy_mode = 0;
  bit src_en = 1, rst_on_pop = 0;
  always #5 clk = ~clk;

  mesh_terminal_rx #(.pckg_sz(P), .fifo_depth(D), .ROW(4'd0), .COL(4'd1)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .pop(pop),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_count(rx_count), .err_count(err_count), .buf_full(buf_full)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [P-1:0] mk(input logic [3:0] r, input logic [3:0] c, input logic [22:0] pl);
    logic [7:0] nj;
    nj = 8'($urandom);
    return {nj, r, c, 1'($urandom), pl};
  endfunction

  task automatic clear_model();
    src.delete(); mq.delete(); pc.delete();
    m_rx = 0; m_err = 0; pops = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pop"}, pop, 0);
    check({tag, "_valid"}, rx_valid, 0);
    check({tag, "_full"}, buf_full, 0);
    check({tag, "_rxcnt"}, rx_count, 0);
    check({tag, "_errcnt"}, err_count, 0);
    check({tag, "_data"}, rx_data, 0);
  endtask

  task automatic do_reset();
    reset = 0; pndng = 0; rx_ready = 0; data_out = '0; src_en = 1;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1; edges = 0; last_pop = -100;
  endtask

  // one clock: check outputs at negedge, advance the model with the values seen there, drive new inputs after the edge
  task automatic tick();
    logic s_pop, s_rd, s_pnd;
    logic [P-1:0] s_d;
    @(negedge clk);
    cyc++;
    if (pop && rst_on_pop) begin
      reset = 0;
      #1;
      check_reset_state("rst_mid_pop");
      rst_on_pop = 0; pndng = 0; rx_ready = 0;
      clear_model();
      return;
    end
    check("rx_valid", rx_valid, mq.size() > 0);
    check("rx_data", rx_data, mq.size() > 0 ? mq[0] : P'(0));
    check("buf_full", buf_full, mq.size() == D);
    check("rx_count", rx_count, 64'(16'(m_rx)));
    check("err_count", err_count, 64'(m_err));
    if (pop) begin
      check("pop_pndng", pndng, 1);
      check("pop_room", mq.size() < D, 1);
      check("pop_gap", cyc - last_pop >= 3, 1);
      check("pop_after_rst", edges >= 1, 1);
      last_pop = cyc; pops++; pc.push_back(cyc);
    end
    s_pop = pop; s_pnd = pndng; s_d = data_out; s_rd = rx_valid && rx_ready;
    @(posedge clk);
    edges++;
    #1;
    if (s_rd && mq.size() > 0) void'(mq.pop_front());
    if (s_pop && s_pnd) begin
      if (src.size() > 0) void'(src.pop_front());
      if (s_d[P-9 -: 4] == 4'd0 && s_d[P-13 -: 4] == 4'd1) begin
        mq.push_back(s_d);
        m_rx++;
      end else if (m_err < 255) m_err++;
    end
    pndng = src_en && src.size() > 0;
    data_out = src.size() > 0 ? src[0] : '0;
    rx_ready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode[0];
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [P-1:0] pkt;
    #1;
    check_reset_state("rst");
    // single matching packet
    do_reset(); rdy_mode = 0;
    pkt = mk(4'd0, 4'd1, 23'hABCDE);
    src.push_back(pkt);
    run(6);
    check("one_pops", pops, 1);
    check("one_rxcnt", rx_count, 1);
    check("one_data", rx_data, pkt);
    // fill to full with host stalled, then a single read admits one more
    do_reset(); rdy_mode = 0;
    for (int i = 0; i < 6; i++) src.push_back(mk(4'd0, 4'd1, 23'($urandom)));
    run(30);
    check("fill_pops", pops, 4);
    check("fill_full", buf_full, 1);
    check("fill_left", src.size(), 2);
    rdy_mode = 1; run(1); rdy_mode = 0;
    run(12);
    check("fifth_pop", pops, 5);
    check("refill_full", buf_full, 1);
    rdy_mode = 1; run(30);
    check("drain_pops", pops, 6);
    check("drain_empty", rx_valid, 0);
    // misrouted packets
    do_reset(); rdy_mode = 1;
    for (int i = 0; i < 3; i++) src.push_back(mk(4'd2, 4'd3, 23'($urandom)));
    run(14);
    check("mis_pops", pops, 3);
    check("mis_err", err_count, 3);
    check("mis_rx", rx_count, 0);
    check("mis_valid", rx_valid, 0);
    // err_count saturation
    do_reset(); rdy_mode = 1;
    for (int i = 0; i < 300; i++) src.push_back(mk(4'd2, 4'd3, 23'($urandom)));
    run(920);
    check("sat_pops", pops, 300);
    check("sat_err", err_count, 255);
    // back-to-back spacing with continuous pending
    do_reset(); rdy_mode = 1;
    for (int i = 0; i < 8; i++) src.push_back(mk(4'd0, 4'd1, 23'($urandom)));
    run(30);
    check("spc_pops", pops, 8);
    for (int i = 1; i < pc.size(); i++) check("spc_gap", pc[i] - pc[i-1], 3);
    // reset asserted during the POP cycle
    do_reset(); rdy_mode = 0;
    for (int i = 0; i < 3; i++) src.push_back(mk(4'd0, 4'd1, 23'($urandom)));
    run(8);
    check("pre_rst_rxcnt", rx_count, 2);
    rst_on_pop = 1;
    for (int i = 0; i < 20 && rst_on_pop; i++) tick();
    check("rst_hit", rst_on_pop, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1; edges = 0; last_pop = -100;
    rdy_mode = 1;
    run(8);
    check("post_rst_valid", rx_valid, 0);
    check("post_rst_data", rx_data, 0);
    // randomized traffic: mixed addresses, bursty pending, random host ready
    do_reset(); rdy_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      if (src.size() < 3 && $urandom_range(0, 1) == 1)
        src.push_back(mk($urandom_range(0, 3) == 0 ? 4'd2 : 4'd0,
                         $urandom_range(0, 3) == 0 ? 4'd3 : 4'd1, 23'($urandom)));
      src_en = $urandom_range(0, 3) != 0;
      tick();
    end
    check("rand_some_rx", m_rx > 20, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mesh_terminal_rx.md
MESH_TERMINAL_RX -- requirements
Module: mesh_terminal_rx

Interface
REQ-001 The block SHALL have parameter pckg_sz, default 40, packet width in bits.
REQ-002 The block SHALL have parameter fifo_depth, default 4, receive-buffer depth in packets (power of two, >= 2).
REQ-003 The block SHALL have parameters ROW and COL, default 0 and 1, the terminal's own mesh coordinates (4 bits each).
REQ-004 Port clk, input, 1, single clock; all logic on rising edge.
REQ-005 Port reset, input, 1, reset is asynchronous and active-low.
REQ-006 Port pndng, input, 1, mesh output pending toward this terminal.
REQ-007 Port data_out, input, pckg_sz, mesh output packet, valid while pndng=1.
REQ-008 Port pop, output, 1, single-cycle pulse consuming the packet on data_out.
REQ-009 Port rx_valid, output, 1, a buffered packet is available to the host.
REQ-010 Port rx_data, output, pckg_sz, head-of-buffer packet.
REQ-011 Port rx_ready, input, 1, host accepts rx_data when rx_valid=1 and rx_ready=1.
REQ-012 Port rx_count, output, 16, packets accepted into the buffer.
REQ-013 Port err_count, output, 8, misrouted packets dropped.
REQ-014 Port buf_full, output, 1, buffer holds fifo_depth packets.

Function
REQ-015 Packet fields SHALL be: [pckg_sz-1:pckg_sz-8] next-jump, [pckg_sz-9:pckg_sz-12] target row, [pckg_sz-13:pckg_sz-16] target column, [pckg_sz-17] mode, remaining bits payload.
REQ-016 The pop-side FSM SHALL have states IDLE, POP, GAP.
REQ-017 IDLE->POP SHALL occur when pndng=1 and the buffer has at least one free slot, counting any slot freed by a host read in that cycle.
REQ-018 In POP, pop SHALL be 1 for exactly one cycle and data_out SHALL be captured on that edge.
REQ-019 POP->GAP SHALL be unconditional, and GAP->IDLE SHALL be unconditional, giving at most one pop every 3 cycles so the mesh pending and data can update.
REQ-020 If pndng drops while in POP, the capture SHALL be discarded, with no write and no count.
REQ-021 A captured packet with target row==ROW and column==COL SHALL be written to the buffer on the capture edge, and rx_count SHALL be incremented.
REQ-022 A captured packet whose row or column mismatches SHALL be dropped without a write, and err_count SHALL be incremented.
REQ-023 rx_count SHALL wrap modulo 2^16.
REQ-024 err_count SHALL saturate at 255.
REQ-025 The buffer SHALL be first-word-fall-through: rx_data SHALL be valid in the same cycle rx_valid rises, with zero-cycle read latency.
REQ-026 Write-to-rx_valid latency SHALL be 1 cycle after the capture edge.
REQ-027 rx_valid SHALL be 1 iff occupancy > 0.
REQ-028 buf_full SHALL be 1 iff occupancy == fifo_depth.
REQ-029 A simultaneous write and read SHALL leave occupancy unchanged, including when the buffer is full.
REQ-030 Read and write pointers SHALL wrap modulo fifo_depth.
REQ-031 rx_ready=1 while rx_valid=0 SHALL have no effect.
REQ-032 rx_data SHALL be held stable while rx_valid=1 and rx_ready=0.
REQ-033 pop SHALL never be asserted while pndng=0 in the same cycle.

Reset
REQ-034 reset=0 SHALL immediately, without a clock edge, force FSM to IDLE, pop=0, rx_valid=0, buf_full=0, rx_count=0, err_count=0, pointers=0, and rx_data=0.
REQ-035 Assertion of reset mid-POP SHALL discard the capture.
REQ-036 After release, the first pop SHALL occur no earlier than the second rising edge after reset returns to 1.
REQ-037 Buffer contents SHALL be considered invalid after reset.

Verification
REQ-038 Bench SHALL cover: reset release, then pndng=1 with data_out of row=0 col=1 and payload 0xABCDE -> pop pulse, rx_valid=1 one cycle later with the same packet, rx_count=1.
REQ-039 Bench SHALL cover: 6 matching packets with rx_ready=0, fifo_depth=4 -> exactly 4 pops, buf_full=1, pop stays 0; one host read -> a 5th pop follows.
REQ-040 Bench SHALL cover: 3 packets addressed to row=2 col=3 -> 3 pops, rx_valid=0, err_count=3, rx_count=0.
REQ-041 Bench SHALL cover: 300 misrouted packets -> err_count=255.
REQ-042 Bench SHALL cover: continuous pndng=1 -> pop pulses spaced exactly 3 cycles; full buffer with rx_ready=1 and a simultaneous write -> occupancy stays 4, order preserved.
REQ-043 Bench SHALL cover: reset=0 asserted in the POP cycle -> pop=0 immediately, counters 0, rx_valid=0, and no stale packet after release.
